// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundle of both master ports plus the RAM pin bus.
// Modports: slave = arbiter side, master = masters/RAM environment side.
interface ram_arbiter_if #(
   parameter int A = 10,
   parameter int D = 8
);
   // master 0 (CPU data port)
   logic         m0_req;
   logic         m0_write;
   logic [A-1:0] m0_addr;
   logic [D-1:0] m0_wdata;
   logic         m0_lock;
   logic         m0_gnt;
   logic         m0_rvalid;
   logic [D-1:0] m0_rdata;
   // master 1 (loader/debug port)
   logic         m1_req;
   logic         m1_write;
   logic [A-1:0] m1_addr;
   logic [D-1:0] m1_wdata;
   logic         m1_lock;
   logic         m1_gnt;
   logic         m1_rvalid;
   logic [D-1:0] m1_rdata;
   // RAM pins
   logic         ram_cs;
   logic         ram_write;
   logic [A-1:0] ram_addr;
   logic [D-1:0] ram_data_in;
   logic [D-1:0] ram_data_out;

   modport slave (
      input  m0_req, m0_write, m0_addr, m0_wdata, m0_lock,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_write, m1_addr, m1_wdata, m1_lock,
      output m1_gnt, m1_rvalid, m1_rdata,
      output ram_cs, ram_write, ram_addr, ram_data_in,
      input  ram_data_out
   );

   modport master (
      output m0_req, m0_write, m0_addr, m0_wdata, m0_lock,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_write, m1_addr, m1_wdata, m1_lock,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  ram_cs, ram_write, ram_addr, ram_data_in,
      output ram_data_out
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master round-robin arbiter in front of a 1-cycle RAM.
// Ports: clk, rst_n (async active-low), bus (ram_arbiter_if.slave).
// Optional macro RAM_ARB_LOCK_EN enables master grant locking.
module ram_arbiter #(
   parameter int A = 10,
   parameter int D = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   ram_arbiter_if.slave  bus
);

   logic [1:0] req;
   logic [1:0] elig;
   logic [1:0] gnt;
   logic       any_gnt;
   logic       gnt_id;
   logic       sel_write;

   logic last_gnt_q, last_gnt_d;
   logic rd_pend_q,  rd_pend_d;
   logic rd_owner_q, rd_owner_d;

   assign req = {bus.m1_req, bus.m0_req};

`ifdef RAM_ARB_LOCK_EN
   logic lock_act_q, lock_act_d;
   logic lock_own_q, lock_own_d;
   logic sel_lock;

   // while locked only the owner is eligible
   always_comb begin
      elig = req;
      if (lock_act_q) begin
         elig = lock_own_q ? (req & 2'b10) : (req & 2'b01);
      end
   end

   assign sel_lock = gnt[1] ? bus.m1_lock : bus.m0_lock;

   always_comb begin
      lock_act_d = lock_act_q;
      lock_own_d = lock_own_q;
      if (any_gnt) begin
         if (sel_lock) begin
            lock_act_d = 1'b1;
            lock_own_d = gnt_id;
         end else begin
            lock_act_d = 1'b0;
         end
      end else if (lock_act_q && !req[lock_own_q]) begin
         lock_act_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_act_q <= 1'b0;
         lock_own_q <= 1'b0;
      end else begin
         lock_act_q <= lock_act_d;
         lock_own_q <= lock_own_d;
      end
   end
`else
   logic unused_lock;
   assign unused_lock = bus.m0_lock ^ bus.m1_lock;
   assign elig = req;
`endif

   // grants are forced low while reset is asserted
   always_comb begin
      gnt = 2'b00;
      if (rst_n) begin
         unique case (1'b1)
            (elig == 2'b11): gnt = last_gnt_q ? 2'b01 : 2'b10;
            (elig == 2'b01): gnt = 2'b01;
            (elig == 2'b10): gnt = 2'b10;
            default:         gnt = 2'b00;
         endcase
      end
   end

   assign any_gnt    = gnt[0] | gnt[1];
   assign gnt_id     = gnt[1];
   assign bus.m0_gnt = gnt[0];
   assign bus.m1_gnt = gnt[1];

   always_comb begin
      bus.ram_cs      = 1'b0;
      bus.ram_write   = 1'b0;
      bus.ram_addr    = '0;
      bus.ram_data_in = '0;
      if (gnt[0]) begin
         bus.ram_cs      = 1'b1;
         bus.ram_write   = bus.m0_write;
         bus.ram_addr    = bus.m0_addr;
         bus.ram_data_in = bus.m0_wdata;
      end else if (gnt[1]) begin
         bus.ram_cs      = 1'b1;
         bus.ram_write   = bus.m1_write;
         bus.ram_addr    = bus.m1_addr;
         bus.ram_data_in = bus.m1_wdata;
      end
   end

   assign sel_write = bus.ram_write;

   always_comb begin
      last_gnt_d = last_gnt_q;
      rd_pend_d  = 1'b0;
      rd_owner_d = rd_owner_q;
      if (any_gnt) begin
         last_gnt_d = gnt_id;
         if (!sel_write) begin
            rd_pend_d  = 1'b1;
            rd_owner_d = gnt_id;
         end
      end
   end

   // last_gnt resets to 1 so master 0 wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_q <= 1'b1;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
      end else begin
         last_gnt_q <= last_gnt_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // RAM data is one cycle late; steer it to the read's owner only
   assign bus.m0_rvalid = rd_pend_q & ~rd_owner_q;
   assign bus.m1_rvalid = rd_pend_q &  rd_owner_q;
   assign bus.m0_rdata  = bus.m0_rvalid ? bus.ram_data_out : '0;
   assign bus.m1_rdata  = bus.m1_rvalid ? bus.ram_data_out : '0;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master arbiter directly upstream of the single-port synchronous RAM.
- Master 0 is the CPU data port; master 1 is the loader/debug port.
- Selects one request per cycle and drives the RAM cs/write/addr/data_in pins.
- Routes the RAM's one-cycle-late read data back to the master that issued the read, with a response-valid strobe.

Parameters:
- A, 10: address width in bits; matches RAM A.
- D, 8: data width in bits; matches RAM D.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 access request; held until granted.
- m0_write  in  1  master 0: 1=write, 0=read.
- m0_addr  in  A  master 0 address.
- m0_wdata  in  D  master 0 write data.
- m0_lock  in  1  master 0 hold-grant request; used only with RAM_ARB_LOCK_EN.
- m0_gnt  out  1  master 0 request accepted this cycle (combinational).
- m0_rvalid  out  1  master 0 read data valid.
- m0_rdata  out  D  master 0 read data.
- m1_req, m1_write, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- ram_cs  out  1  to RAM cs.
- ram_write  out  1  to RAM write.
- ram_addr  out  A  to RAM addr.
- ram_data_in  out  D  to RAM data_in.
- ram_data_out  in  D  from RAM data_out.

Behaviour:
- Registered state:
  - last_gnt (1b): master granted most recently.
  - rd_pend (1b): a read was issued last cycle.
  - rd_owner (1b): master that issued that read.
  - Optional lock_own / lock_act (see Optional Feature).
- Reset (rst_n low, asynchronous): last_gnt=1 (master 0 wins the first tie), rd_pend=0, rd_owner=0, m0_rvalid=m1_rvalid=0.
- Combinational outputs while rst_n is low: gnt=0, ram_cs=0.
- Arbitration is combinational, same cycle:
  - Only m0_req: grant 0.
  - Only m1_req: grant 1.
  - Both: grant !last_gnt (round-robin).
  - Neither: no grant.
- Exactly one gnt is high at most; gnt is never asserted without the matching req.
- RAM drive:
  - ram_cs = any grant.
  - ram_write, ram_addr, ram_data_in are muxed from the granted master.
  - With no grant: ram_cs=0, ram_write=0, ram_addr=0, ram_data_in=0.
- Write: completes at the granted clock edge. No response strobe.
- Read, granted in cycle N:
  - Edge at end of N: rd_pend<=1, rd_owner<=granted master.
  - Cycle N+1: owner's rvalid=1 and owner's rdata=ram_data_out.
  - Read latency is 1 cycle from grant to rvalid.
- The non-owner's rvalid stays 0. Both rdata outputs are 0 when their rvalid is low.
- Back-to-back reads, including alternating masters, sustain one per cycle. Each rvalid follows its own grant by exactly one cycle.
- Grant update: last_gnt updates on every granted edge to the granted master. It holds when there is no grant.
- A master that keeps req high with the other idle is granted every cycle (no forced bubbles).
- Mid-operation reset: a pending read response is dropped; rvalid is low after reset release.
- A write granted in the same cycle that a previous read response returns is legal; both proceed.

Optional Feature:
- Macro: RAM_ARB_LOCK_EN.
- Defined:
  - A granted master with mX_lock=1 sets lock_act=1 and lock_own=X.
  - While lock_act=1, only lock_own can be granted; the other master is stalled even if it requested.
  - lock_act clears on the first granted access with mX_lock=0, or on any cycle lock_own has req=0.
  - Reset clears lock_act.
  - Round-robin resumes from last_gnt.
- Not defined: m0_lock/m1_lock are ignored, no lock registers exist, and pure round-robin applies.

Test Plan:
- Reset release, m0 write addr 0x005 data 0xA5, then m0 read 0x005 -> m0_gnt both cycles; m0_rvalid high exactly one cycle after the read grant; m0_rdata=0xA5; m1_rvalid=0 throughout.
- m0 and m1 both request reads every cycle for 6 cycles -> grants alternate 0,1,0,1,0,1 starting with m0; each mX_rvalid follows its grant by one cycle with the correct data.
- m1 alone requests 4 consecutive writes 0x10..0x13 to 0x100..0x103 -> m1_gnt high 4 consecutive cycles; readback returns the same values.
- m0 read granted, rst_n pulsed low before the next edge -> m0_rvalid stays 0; last_gnt=1 after release, so the next tie goes to m0.
- RAM_ARB_LOCK_EN: m1 requests with lock=1 for 3 accesses then lock=0 while m0 requests continuously -> m0 stalled for 4 m1 grants, then m0 granted next cycle.
- Both idle -> ram_cs=0, ram_write=0, ram_addr=0, no rvalid, last_gnt unchanged.
